// File: rtl/inverter_bank.sv
// -----------------------------------------------------------------------------
// inverter_bank
//
// A bank of WIDTH independent input channels. Each channel is synchronised
// through two flops, debounced (a change is accepted only after DEBOUNCE
// consecutive enabled samples that disagree with the accepted state), and
// driven out through a per-channel polarity inversion. Accepted 0->1 and 1->0
// transitions produce one-cycle RISE / FALL pulses; ANY_EDGE is their OR.
//
// Parameters
//   WIDTH     number of channels (>= 1)
//   DEBOUNCE  consecutive mismatching samples needed to accept a change (>= 1)
//
// Ports
//   CLK       clock, all state updates on the rising edge
//   RST       synchronous, active-high reset
//   I         raw asynchronous channel inputs
//   POL       per-channel polarity (1 = invert, 0 = pass through)
//   EN        global enable; while low the synchroniser keeps sampling,
//             accepted state and O hold, counters clear, pulses are 0
//   O         registered, debounced, polarity-applied outputs
//   RISE      one-cycle pulse per accepted 0->1 transition
//   FALL      one-cycle pulse per accepted 1->0 transition
//   ANY_EDGE  OR of all RISE and FALL bits, same cycle
// -----------------------------------------------------------------------------
module inverter_bank #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] POL,
  input  logic             EN,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             ANY_EDGE
);

  // Counter must hold 0..DEBOUNCE-1; keep at least one bit.
  localparam int CW_RAW = $clog2(DEBOUNCE + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [WIDTH-1:0]         s1_r;
  logic [WIDTH-1:0]         s2_r;
  logic [WIDTH-1:0]         st_r;
  logic [WIDTH-1:0][CW-1:0] cnt_r;

  logic [WIDTH-1:0]         st_next_s;
  logic [WIDTH-1:0][CW-1:0] cnt_next_s;
  logic [WIDTH-1:0]         rise_next_s;
  logic [WIDTH-1:0]         fall_next_s;
  logic [WIDTH-1:0]         o_next_s;
  logic                     any_next_s;

  // Per-channel debounce: next accepted state, counter and edge pulses.
  always_comb begin
    st_next_s   = st_r;
    cnt_next_s  = cnt_r;
    rise_next_s = {WIDTH{1'b0}};
    fall_next_s = {WIDTH{1'b0}};
    for (int c = 0; c < WIDTH; c++) begin
      if (EN) begin
        if (s2_r[c] != st_r[c]) begin
          if (cnt_r[c] == CNT_LAST) begin
            // This is the DEBOUNCE-th consecutive mismatch: accept it.
            st_next_s[c]   = s2_r[c];
            cnt_next_s[c]  = CNT_ZERO;
            rise_next_s[c] = s2_r[c];
            fall_next_s[c] = ~s2_r[c];
          end else begin
            cnt_next_s[c] = cnt_r[c] + CNT_ONE;
          end
        end else begin
          // Agreement with the accepted state discards any partial count.
          cnt_next_s[c] = CNT_ZERO;
        end
      end else begin
        // Disabled: hold state, restart the debounce from zero later.
        cnt_next_s[c] = CNT_ZERO;
      end
    end
  end

  // Output value and edge summary derived from the next accepted state.
  always_comb begin
    any_next_s = |(rise_next_s | fall_next_s);
    if (EN) begin
      o_next_s = st_next_s ^ POL;
    end else begin
      o_next_s = O;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_r     <= {WIDTH{1'b0}};
      s2_r     <= {WIDTH{1'b0}};
      st_r     <= {WIDTH{1'b0}};
      cnt_r    <= '0;
      O        <= {WIDTH{1'b0}};
      RISE     <= {WIDTH{1'b0}};
      FALL     <= {WIDTH{1'b0}};
      ANY_EDGE <= 1'b0;
    end else begin
      s1_r     <= I;
      s2_r     <= s1_r;
      st_r     <= st_next_s;
      cnt_r    <= cnt_next_s;
      O        <= o_next_s;
      RISE     <= rise_next_s;
      FALL     <= fall_next_s;
      ANY_EDGE <= any_next_s;
    end
  end

  inverter_bank_checker #(
    .WIDTH (WIDTH),
    .CW    (CW),
    .LAST  (CNT_LAST)
  ) u_checker (
    .CLK      (CLK),
    .cnt      (cnt_r),
    .RISE     (RISE),
    .FALL     (FALL),
    .ANY_EDGE (ANY_EDGE)
  );

endmodule

// -----------------------------------------------------------------------------
// inverter_bank_checker
//
// Structural invariants of inverter_bank: counters never pass DEBOUNCE-1,
// RISE and FALL never coincide on a channel, and ANY_EDGE is their OR.
//
// Ports
//   CLK       clock
//   cnt       per-channel debounce counters
//   RISE      rise pulses
//   FALL      fall pulses
//   ANY_EDGE  edge summary
// -----------------------------------------------------------------------------
module inverter_bank_checker #(
  parameter int            WIDTH = 8,
  parameter int            CW    = 3,
  parameter logic [CW-1:0] LAST  = '0
) (
  input logic                     CLK,
  input logic [WIDTH-1:0][CW-1:0] cnt,
  input logic [WIDTH-1:0]         RISE,
  input logic [WIDTH-1:0]         FALL,
  input logic                     ANY_EDGE
);

  a_no_double_edge: assert property (@(posedge CLK) (RISE & FALL) == {WIDTH{1'b0}});
  a_any_edge:       assert property (@(posedge CLK) ANY_EDGE == |(RISE | FALL));

  for (genvar c = 0; c < WIDTH; c++) begin : g_cnt
    a_cnt_bound: assert property (@(posedge CLK) cnt[c] <= LAST);
  end

endmodule

// File: tb/tb_inverter_bank.sv
module tb_inverter_bank;

  localparam int W    = 8;
  localparam int MAXE = 4096;

  logic         CLK;
  logic         RST;
  logic [W-1:0] I;
  logic [W-1:0] POL;
  logic         EN;

  logic [W-1:0] o4, rise4, fall4;
  logic         any4;
  logic [W-1:0] o1, rise1, fall1;
  logic         any1;

  int checks;
  int errors;

  inverter_bank #(.WIDTH(W), .DEBOUNCE(4)) dut (
    .CLK(CLK), .RST(RST), .I(I), .POL(POL), .EN(EN),
    .O(o4), .RISE(rise4), .FALL(fall4), .ANY_EDGE(any4)
  );

  inverter_bank #(.WIDTH(W), .DEBOUNCE(1)) dut1 (
    .CLK(CLK), .RST(RST), .I(I), .POL(POL), .EN(EN),
    .O(o1), .RISE(rise1), .FALL(fall1), .ANY_EDGE(any1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------------------------------------------------------------------
  // Reference model, index 0 = DEBOUNCE 4, index 1 = DEBOUNCE 1.
  // A change is accepted at an edge when the synchronised sample disagreed
  // with the accepted state at each of the last D edges (enabled, not in
  // reset) and all of those edges lie after the previous acceptance.
  // ---------------------------------------------------------------------------
  logic [W-1:0] m_s1 [2];
  logic [W-1:0] m_s2 [2];
  logic [W-1:0] m_st [2];
  logic [W-1:0] m_o  [2];
  logic [W-1:0] m_r  [2];
  logic [W-1:0] m_f  [2];
  logic         m_a  [2];
  logic [W-1:0] mis_h [2][MAXE];
  int           last_acc [2][W];
  int           edge_n;

  function automatic int dof(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (RST) begin
        m_s1[k] = '0; m_s2[k] = '0; m_st[k] = '0; m_o[k] = '0;
        m_r[k] = '0; m_f[k] = '0; m_a[k] = 1'b0;
        mis_h[k][edge_n] = '0;
      end else begin
        logic [W-1:0] nst, r, f;
        nst = m_st[k]; r = '0; f = '0;
        for (int c = 0; c < W; c++) begin
          bit acc;
          mis_h[k][edge_n][c] = EN && (m_s2[k][c] != m_st[k][c]);
          acc = 1'b1;
          for (int j = 0; j < dof(k); j++) begin
            int e;
            e = edge_n - j;
            if (e < 0 || e <= last_acc[k][c]) acc = 1'b0;
            else if (!mis_h[k][e][c]) acc = 1'b0;
          end
          if (acc) begin
            nst[c] = m_s2[k][c];
            last_acc[k][c] = edge_n;
            if (m_s2[k][c]) r[c] = 1'b1; else f[c] = 1'b1;
          end
        end
        m_st[k] = nst; m_r[k] = r; m_f[k] = f; m_a[k] = (r != 0) || (f != 0);
        if (EN) m_o[k] = nst ^ POL;
        m_s2[k] = m_s1[k];
        m_s1[k] = I;
      end
    end
    if (edge_n < MAXE - 1) edge_n++;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; I = '0; POL = '0; EN = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    RST = 1'b1; EN = 1'b1; POL = 8'hFF;
    for (int n = 0; n < 3; n++) begin
      I = W'($urandom);
      tick();
      checks++;
      if ({o4, rise4, fall4, any4} !== 25'h0) begin
        errors++;
        $display("FAIL reset_dut4: got O=%h R=%h F=%h A=%b, want all 0", o4, rise4, fall4, any4);
      end
      checks++;
      if ({o1, rise1, fall1, any1} !== 25'h0) begin
        errors++;
        $display("FAIL reset_dut1: got O=%h R=%h F=%h A=%b, want all 0", o1, rise1, fall1, any1);
      end
    end
    RST = 1'b0; POL = 8'h3C; I = '0;
    tick();
    checks++;
    if ({o4, rise4, fall4, any4} !== {8'h3C, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_release: got O=%h R=%h F=%h A=%b, want O=3c no pulses", o4, rise4, fall4, any4);
    end
  endtask

  task automatic test_single_rise();
    do_reset();
    tick(); tick();
    I = 8'h01;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if ({o4, rise4, any4} !== 17'h0) begin
        errors++;
        $display("FAIL rise_early n=%0d: got O=%h R=%h A=%b, want 0", n, o4, rise4, any4);
      end
    end
    tick();
    checks++;
    if ({o4, rise4, fall4, any4} !== {8'h01, 8'h01, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL rise_accept: got O=%h R=%h F=%h A=%b, want O=01 R=01 F=00 A=1", o4, rise4, fall4, any4);
    end
    tick();
    checks++;
    if ({o4, rise4, fall4, any4} !== {8'h01, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL rise_one_cycle: got O=%h R=%h F=%h A=%b, want O=01 no pulses", o4, rise4, fall4, any4);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    tick(); tick();
    for (int n = 0; n < 12; n++) begin
      I = (n < 3) ? 8'h01 : 8'h00;
      tick();
      checks++;
      if ({o4, rise4, fall4, any4} !== 25'h0) begin
        errors++;
        $display("FAIL glitch n=%0d: got O=%h R=%h F=%h A=%b, want all 0", n, o4, rise4, fall4, any4);
      end
    end
  endtask

  task automatic test_polarity();
    do_reset();
    tick(); tick(); tick();
    POL = 8'hA5;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if ({o4, rise4, fall4, any4} !== {8'hA5, 8'h00, 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL polarity n=%0d: got O=%h R=%h F=%h A=%b, want O=a5 no pulses", n, o4, rise4, fall4, any4);
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    tick(); tick();
    I = 8'hFF;
    for (int n = 0; n < 4; n++) tick();
    EN = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if ({o4, rise4, fall4, any4} !== 25'h0) begin
        errors++;
        $display("FAIL enable_hold n=%0d: got O=%h R=%h F=%h A=%b, want all 0", n, o4, rise4, fall4, any4);
      end
    end
    EN = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if ({o4, rise4} !== 16'h0) begin
        errors++;
        $display("FAIL enable_restart n=%0d: got O=%h R=%h, want 0", n, o4, rise4);
      end
    end
    tick();
    checks++;
    if ({o4, rise4, fall4, any4} !== {8'hFF, 8'hFF, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL enable_accept: got O=%h R=%h F=%h A=%b, want O=ff R=ff A=1", o4, rise4, fall4, any4);
    end
    tick();
    checks++;
    if ({rise4, any4} !== 9'h0) begin
      errors++;
      $display("FAIL enable_one_cycle: got R=%h A=%b, want 0", rise4, any4);
    end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    tick(); tick();
    I = 8'h04;
    for (int n = 0; n < 5; n++) tick();
    RST = 1'b1;
    tick();
    checks++;
    if ({o4, rise4, fall4, any4} !== 25'h0) begin
      errors++;
      $display("FAIL midcount_reset: got O=%h R=%h F=%h A=%b, want all 0", o4, rise4, fall4, any4);
    end
    RST = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if ({o4, rise4} !== 16'h0) begin
        errors++;
        $display("FAIL midcount_early n=%0d: got O=%h R=%h, want 0", n, o4, rise4);
      end
    end
    tick();
    checks++;
    if ({o4, rise4, any4} !== {8'h04, 8'h04, 1'b1}) begin
      errors++;
      $display("FAIL midcount_accept: got O=%h R=%h A=%b, want O=04 R=04 A=1", o4, rise4, any4);
    end
  endtask

  task automatic test_debounce1();
    do_reset();
    I = 8'h80;
    for (int n = 0; n < 5; n++) tick();
    I = 8'h01;
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++;
      if ({o1, rise1, fall1, any1} !== {8'h80, 8'h00, 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL db1_early n=%0d: got O=%h R=%h F=%h A=%b, want O=80 no pulses", n, o1, rise1, fall1, any1);
      end
    end
    tick();
    checks++;
    if ({o1, rise1, fall1, any1} !== {8'h01, 8'h01, 8'h80, 1'b1}) begin
      errors++;
      $display("FAIL db1_toggle: got O=%h R=%h F=%h A=%b, want O=01 R=01 F=80 A=1", o1, rise1, fall1, any1);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] mask;
    for (int n = 0; n < 500; n++) begin
      RST = ($urandom_range(0, 99) == 0);
      EN  = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) POL = W'($urandom);
      mask = '0;
      for (int c = 0; c < W; c++) mask[c] = ($urandom_range(0, 5) == 0);
      I = I ^ mask;
      tick();
      checks++;
      if ({o4, rise4, fall4, any4} !== {m_o[0], m_r[0], m_f[0], m_a[0]}) begin
        errors++;
        $display("FAIL rand_dut4 n=%0d: got O=%h R=%h F=%h A=%b, want O=%h R=%h F=%h A=%b",
                 n, o4, rise4, fall4, any4, m_o[0], m_r[0], m_f[0], m_a[0]);
      end
      checks++;
      if ({o1, rise1, fall1, any1} !== {m_o[1], m_r[1], m_f[1], m_a[1]}) begin
        errors++;
        $display("FAIL rand_dut1 n=%0d: got O=%h R=%h F=%h A=%b, want O=%h R=%h F=%h A=%b",
                 n, o1, rise1, fall1, any1, m_o[1], m_r[1], m_f[1], m_a[1]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edge_n = 0;
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = '0; m_s2[k] = '0; m_st[k] = '0; m_o[k] = '0;
      m_r[k] = '0; m_f[k] = '0; m_a[k] = 1'b0;
      for (int c = 0; c < W; c++) last_acc[k][c] = -1;
    end
    RST = 1'b1; EN = 1'b0; I = '0; POL = '0;

    test_reset();
    test_single_rise();
    test_glitch();
    test_polarity();
    test_enable();
    test_reset_midcount();
    test_debounce1();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
